// File: rtl/compare_iter_nb.sv
// Iterative signed/unsigned comparator that scans W bits per cycle from the MSB chunk
// and exits at the first differing chunk; result returned as a zero-extended SLT/SGE bit.
module compare_iter_nb #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] res_o
);

    localparam int unsigned NC = N / W;
    localparam int unsigned CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, b_q;
    logic [N-1:0]  a_cap, b_cap;
    logic          inv_q;
    logic [CW-1:0] cnt_q;
    logic          res_bit_q;
    logic          accept, finish, lt_d;
    logic [W-1:0]  a_top, b_top;

    // Operands shift left each SCAN cycle, so the chunk under test is always the top one.
    assign a_top = a_q[N-1 -: W];
    assign b_top = b_q[N-1 -: W];

    always_comb begin
        a_cap = a_i;
        b_cap = b_i;
        // Offset-binary bias turns the signed order into the unsigned one.
        if (!op_i[0]) begin
            a_cap[N-1] = ~a_i[N-1];
            b_cap[N-1] = ~b_i[N-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        lt_d        = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (a_top != b_top) begin
                    finish = 1'b1;
                    lt_d   = (a_top < b_top);
                end else if (cnt_q == '0) begin
                    finish = 1'b1;
                end
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_q       <= '0;
            b_q       <= '0;
            inv_q     <= 1'b0;
            cnt_q     <= '0;
            res_bit_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a_cap;
            b_q   <= b_cap;
            inv_q <= op_i[1];
            cnt_q <= CW'(NC - 1);
        end else if (state_q == SCAN) begin
            if (finish) begin
                res_bit_q <= lt_d ^ inv_q;
            end else begin
                a_q   <= a_q << W;
                b_q   <= b_q << W;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign res_o = {{(N-1){1'b0}}, res_bit_q};

endmodule

// File: tb/tb_compare_iter_nb.sv
// Directed and randomized checks of compare_iter_nb against a behavioural compare model.
module tb_compare_iter_nb;

    localparam int unsigned N  = 32;
    localparam int unsigned W  = 8;
    localparam int unsigned NC = N / W;

    logic         clk = 1'b0;
    logic         rstn_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [N-1:0] a_i, b_i;
    logic [1:0]   op_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [N-1:0] res_o;

    int errors = 0;
    int checks = 0;

    compare_iter_nb #(.N(N), .W(W)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_res(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [1:0] op);
        logic lt;
        lt = op[0] ? (a < b) : ($signed(a) < $signed(b));
        return lt ^ op[1];
    endfunction

    function automatic int model_lat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        d = a ^ b;
        if (d == '0) return NC;
        for (int p = N - 1; p >= 0; p--) begin
            if (d[p]) return (N - 1 - p) / W + 1;
        end
        return NC;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [1:0] op, input int hold, input string tag);
        logic [N-1:0] exp_r;
        int lat;
        exp_r = {{(N-1){1'b0}}, model_res(a, b, op)};
        chk({tag, ".in_ready_idle"}, {31'b0, in_ready_o}, 1);
        a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, N'(lat), N'(model_lat(a, b)));
        chk({tag, ".res"}, res_o, exp_r);
        chk({tag, ".in_ready_busy"}, {31'b0, in_ready_o}, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_valid"}, {31'b0, out_valid_o}, 1);
            chk({tag, ".hold_res"}, res_o, exp_r);
            chk({tag, ".hold_in_ready"}, {31'b0, in_ready_o}, 0);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk({tag, ".valid_after_hs"}, {31'b0, out_valid_o}, 0);
        chk({tag, ".ready_after_hs"}, {31'b0, in_ready_o}, 1);
        chk({tag, ".res_retained"}, res_o, exp_r);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [N-1:0] mask;
        rstn_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; op_i = '0;
        step();
        step();
        chk("reset.in_ready", {31'b0, in_ready_o}, 1);
        chk("reset.out_valid", {31'b0, out_valid_o}, 0);
        chk("reset.res", res_o, 0);
        rstn_i = 1'b1;
        step();

        run_op(32'hFFFFFFFF, 32'h00000001, 2'b00, 0, "t1_slt_neg");
        run_op(32'hFFFFFFFF, 32'h00000001, 2'b01, 0, "t2_sltu");
        run_op(32'hFFFFFFFF, 32'h00000001, 2'b11, 0, "t2_sgeu");
        run_op(32'h12345600, 32'h12345601, 2'b01, 0, "t3_sltu_lsb");
        run_op(32'h80000000, 32'h80000000, 2'b10, 0, "t4_sge_eq");
        run_op(32'h80000000, 32'h80000000, 2'b00, 0, "t4_slt_eq");
        run_op(32'h80000000, 32'h7FFFFFFF, 2'b00, 3, "t5_slt_minmax");

        // Reset mid-scan after a result-1 op so a stale res_o would be visible.
        run_op(32'h00000000, 32'h00000001, 2'b01, 0, "t6_pre");
        a_i = 32'hCAFEBABE; b_i = 32'hCAFEBABE; op_i = 2'b01; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        rstn_i = 1'b0;
        step();
        chk("t6.rst_valid", {31'b0, out_valid_o}, 0);
        chk("t6.rst_res", res_o, 0);
        chk("t6.rst_ready", {31'b0, in_ready_o}, 1);
        rstn_i = 1'b1;
        for (int i = 0; i < NC + 2; i++) begin
            step();
            chk("t6.no_stale", {31'b0, out_valid_o}, 0);
        end
        run_op(32'd3, 32'd5, 2'b01, 0, "t6_post");

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = ra;
            mask = '0;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: begin
                    mask = N'($urandom_range(1, 255)) << (W * $urandom_range(0, NC - 1));
                    rb = ra ^ mask;
                end
                default: rb = ra ^ (N'(1) << (N - 1));
            endcase
            run_op(ra, rb, 2'($urandom), $urandom_range(0, 2), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
